// File: rtl/bcd_conv_arb_if.sv
// Request/grant and result handshake bundle for the shared binary-to-BCD engine.
// The engine connects to the slave modport; requesters and consumer use master.
interface bcd_conv_arb_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  iREQ0;
    logic [BIN_W-1:0]      iBIN0;
    logic                  oGNT0;
    logic                  iREQ1;
    logic [BIN_W-1:0]      iBIN1;
    logic                  oGNT1;
    logic                  oBUSY;
    logic                  oVALID;
    logic [4*DIGITS-1:0]   oBCD;
    logic                  oSRC;
    logic                  iREADY;

    modport slave (
        input  iREQ0, iBIN0, iREQ1, iBIN1, iREADY,
        output oGNT0, oGNT1, oBUSY, oVALID, oBCD, oSRC
    );

    modport master (
        output iREQ0, iBIN0, iREQ1, iBIN1, iREADY,
        input  oGNT0, oGNT1, oBUSY, oVALID, oBCD, oSRC
    );
endinterface

// File: rtl/bcd_conv_arb.sv
// Time-shared double-dabble binary-to-BCD engine with a two-way round-robin arbiter.
// One shift per clock; the result is held on a valid/ready output until accepted.
module bcd_conv_arb #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input logic           iCLK,
    input logic           iRSTn,
    bcd_conv_arb_if.slave bus
);
    localparam int unsigned CntW = $clog2(BIN_W);
    localparam int unsigned BcdW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StShift, StDone} stateT;

    stateT            state;
    logic             ptr;
    logic             winner;
    logic             gnt0;
    logic             gnt1;
    logic             valid;
    logic             src;
    logic [CntW-1:0]  cnt;
    logic [BIN_W-1:0] binSh;
    logic [BcdW-1:0]  bcdAcc;
    logic [BcdW-1:0]  bcdAdj;
    logic [BcdW-1:0]  bcdNext;
    logic [BcdW-1:0]  bcdOut;
    logic             pick;

    // Per-digit +3 adjust; digits never carry into each other.
    always_comb begin
        bcdAdj = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcdAcc[4*i +: 4] >= 4'd5) begin
                bcdAdj[4*i +: 4] = bcdAcc[4*i +: 4] + 4'd3;
            end else begin
                bcdAdj[4*i +: 4] = bcdAcc[4*i +: 4];
            end
        end
        bcdNext = (bcdAdj << 1) | BcdW'(binSh[BIN_W-1]);
    end

    // pick=1 selects requester 1; the pointer only matters when both are asking.
    assign pick = (bus.iREQ0 && bus.iREQ1) ? ptr : bus.iREQ1;

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state  <= StIdle;
            ptr    <= 1'b0;
            winner <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            valid  <= 1'b0;
            src    <= 1'b0;
            cnt    <= '0;
            binSh  <= '0;
            bcdAcc <= '0;
            bcdOut <= '0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.iREQ0 || bus.iREQ1) begin
                        winner <= pick;
                        ptr    <= ~pick;
                        gnt0   <= ~pick;
                        gnt1   <= pick;
                        binSh  <= pick ? bus.iBIN1 : bus.iBIN0;
                        bcdAcc <= '0;
                        cnt    <= '0;
                        state  <= StShift;
                    end
                end
                StShift: begin
                    bcdAcc <= bcdNext;
                    binSh  <= binSh << 1;
                    cnt    <= cnt + CntW'(1);
                    if (cnt == CntW'(BIN_W - 1)) begin
                        bcdOut <= bcdNext;
                        src    <= winner;
                        valid  <= 1'b1;
                        state  <= StDone;
                    end
                end
                StDone: begin
                    if (bus.iREADY) begin
                        valid <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.oGNT0  = gnt0;
    assign bus.oGNT1  = gnt1;
    assign bus.oBUSY  = (state != StIdle);
    assign bus.oVALID = valid;
    assign bus.oBCD   = bcdOut;
    assign bus.oSRC   = src;
endmodule

// File: tb/tb_bcd_conv_arb.sv
// Bench for bcd_conv_arb: default 8-bit instance plus a 10-bit/4-digit instance,
// checked against a decimal-arithmetic model and a round-robin pointer model.
module tb_bcd_conv_arb;
    logic clk = 1'b0;
    logic rstN;
    int   tests = 0;
    int   fails = 0;
    bit   ptrM;

    always #5 clk = ~clk;

    bcd_conv_arb_if #(.BIN_W(8), .DIGITS(3)) nIf ();
    bcd_conv_arb_if #(.BIN_W(10), .DIGITS(4)) wIf ();

    bcd_conv_arb #(.BIN_W(8), .DIGITS(3)) dutN (
        .iCLK  (clk),
        .iRSTn (rstN),
        .bus   (nIf)
    );

    bcd_conv_arb #(.BIN_W(10), .DIGITS(4)) dutW (
        .iCLK  (clk),
        .iRSTn (rstN),
        .bus   (wIf)
    );

    function automatic int toBcd(input int v, input int digits);
        int r = 0;
        int p = 1;
        for (int i = 0; i < digits; i++) begin
            r += ((v / p) % 10) << (4 * i);
            p *= 10;
        end
        return r;
    endfunction

    // Caller has requests set up with the engine idle; runs one full conversion.
    task automatic convert(input string name, input bit accept);
        int          n = 0;
        int          lat = 0;
        bit          expWin;
        bit          sawGnt = 0;
        int          expVal;
        logic [11:0] expBcd;
        if (nIf.iREQ0 && nIf.iREQ1) expWin = ptrM;
        else expWin = nIf.iREQ1;
        expVal = expWin ? int'(nIf.iBIN1) : int'(nIf.iBIN0);
        ptrM   = !expWin;
        expBcd = 12'(toBcd(expVal, 3));
        do begin
            @(negedge clk);
            n++;
        end while (!(nIf.oGNT0 || nIf.oGNT1) && n < 40);
        tests++;
        if ({nIf.oGNT1, nIf.oGNT0} !== (expWin ? 2'b10 : 2'b01) || n != 1) begin
            fails++;
            $display("FAIL %s grant: gnt=%b after %0d cycles, required gnt=%b after 1",
                     name, {nIf.oGNT1, nIf.oGNT0}, n, expWin ? 2'b10 : 2'b01);
            if (n >= 40) begin
                nIf.iREQ0 = 1'b0;
                nIf.iREQ1 = 1'b0;
                return;
            end
        end
        // Operand changes after grant must not disturb the conversion.
        if (expWin) begin
            nIf.iREQ1 = 1'b0;
            nIf.iBIN1 = 8'($urandom);
        end else begin
            nIf.iREQ0 = 1'b0;
            nIf.iBIN0 = 8'($urandom);
        end
        do begin
            @(negedge clk);
            lat++;
            if (nIf.oGNT0 || nIf.oGNT1) sawGnt = 1;
        end while (nIf.oVALID !== 1'b1 && lat < 40);
        tests++;
        if (lat != 8 || sawGnt) begin
            fails++;
            $display("FAIL %s latency: valid after %0d cycles (stray grant=%0d), required 8 (0)",
                     name, lat, sawGnt);
        end
        tests++;
        if (nIf.oBCD !== expBcd || nIf.oSRC !== expWin || nIf.oBUSY !== 1'b1) begin
            fails++;
            $display("FAIL %s result: bcd=%h src=%b busy=%b, required bcd=%h src=%b busy=1",
                     name, nIf.oBCD, nIf.oSRC, nIf.oBUSY, expBcd, expWin);
        end
        if (accept) begin
            nIf.iREADY = 1'b1;
            @(negedge clk);
            nIf.iREADY = 1'b0;
            tests++;
            if (nIf.oVALID !== 1'b0 || nIf.oBUSY !== 1'b0 || nIf.oBCD !== expBcd) begin
                fails++;
                $display("FAIL %s accept: valid=%b busy=%b bcd=%h, required 0 0 %h",
                         name, nIf.oVALID, nIf.oBUSY, nIf.oBCD, expBcd);
            end
        end
    endtask

    task automatic pulseReset();
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        ptrM = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({nIf.oGNT0, nIf.oGNT1, nIf.oBUSY, nIf.oVALID, nIf.oSRC} !== 5'b0
            || nIf.oBCD !== 12'h000) begin
            fails++;
            $display("FAIL reset: gnt0/gnt1/busy/valid/src=%b bcd=%h, required all 0",
                     {nIf.oGNT0, nIf.oGNT1, nIf.oBUSY, nIf.oVALID, nIf.oSRC}, nIf.oBCD);
        end
        tests++;
        if (wIf.oBUSY !== 1'b0 || wIf.oVALID !== 1'b0 || wIf.oBCD !== 16'h0000) begin
            fails++;
            $display("FAIL reset_wide: busy=%b valid=%b bcd=%h, required 0 0 0000",
                     wIf.oBUSY, wIf.oVALID, wIf.oBCD);
        end
        rstN = 1'b1;
        ptrM = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        nIf.iREQ0 = 1'b1;
        nIf.iBIN0 = 8'd255;
        convert("single_255", 1);
    endtask

    task automatic test_boundary();
        nIf.iREQ1 = 1'b1;
        nIf.iBIN1 = 8'd0;
        convert("bound_0", 1);
        nIf.iREQ0 = 1'b1;
        nIf.iBIN0 = 8'd9;
        convert("bound_9", 1);
        nIf.iREQ0 = 1'b1;
        nIf.iBIN0 = 8'd100;
        convert("bound_100", 1);
    endtask

    task automatic test_simultaneous();
        pulseReset();
        nIf.iREQ0 = 1'b1;
        nIf.iBIN0 = 8'd42;
        nIf.iREQ1 = 1'b1;
        nIf.iBIN1 = 8'd199;
        convert("simul_first", 1);
        convert("simul_second", 1);
        nIf.iREQ0 = 1'b1;
        nIf.iBIN0 = 8'($urandom);
        nIf.iREQ1 = 1'b1;
        nIf.iBIN1 = 8'($urandom);
        convert("simul_third", 1);
        convert("simul_fourth", 1);
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 16; it++) begin
            if (!nIf.iREQ0 && $urandom_range(0, 1) == 1) begin
                nIf.iREQ0 = 1'b1;
                nIf.iBIN0 = 8'($urandom);
            end
            if (!nIf.iREQ1 && $urandom_range(0, 1) == 1) begin
                nIf.iREQ1 = 1'b1;
                nIf.iBIN1 = 8'($urandom);
            end
            if (!nIf.iREQ0 && !nIf.iREQ1) begin
                nIf.iREQ0 = 1'b1;
                nIf.iBIN0 = 8'($urandom);
            end
            convert("rand", 1);
        end
        while (nIf.iREQ0 || nIf.iREQ1) convert("drain", 1);
    endtask

    task automatic test_backpressure();
        logic [11:0] held;
        logic        heldSrc;
        bit          moved = 0;
        nIf.iREQ0 = 1'b1;
        nIf.iBIN0 = 8'($urandom);
        convert("bp_hold", 0);
        held      = nIf.oBCD;
        heldSrc   = nIf.oSRC;
        nIf.iREQ1 = 1'b1;
        nIf.iBIN1 = 8'($urandom);
        repeat (20) begin
            @(negedge clk);
            if (nIf.oVALID !== 1'b1 || nIf.oBCD !== held || nIf.oSRC !== heldSrc
                || nIf.oGNT0 || nIf.oGNT1) moved = 1;
        end
        tests++;
        if (moved) begin
            fails++;
            $display("FAIL bp_stable: output changed or grant seen (now valid=%b bcd=%h), required %h held",
                     nIf.oVALID, nIf.oBCD, held);
        end
        nIf.iREADY = 1'b1;
        @(negedge clk);
        nIf.iREADY = 1'b0;
        tests++;
        if (nIf.oVALID !== 1'b0 || nIf.oGNT1 !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept: valid=%b gnt1=%b, required 0 0", nIf.oVALID, nIf.oGNT1);
        end
        convert("bp_next", 1);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        nIf.iREQ0 = 1'b1;
        nIf.iBIN0 = 8'd77;
        do begin
            @(negedge clk);
            n++;
        end while (!nIf.oGNT0 && n < 40);
        nIf.iREQ0 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        tests++;
        if ({nIf.oGNT0, nIf.oGNT1, nIf.oBUSY, nIf.oVALID, nIf.oSRC} !== 5'b0
            || nIf.oBCD !== 12'h000 || n >= 40) begin
            fails++;
            $display("FAIL reset_mid: flags=%b bcd=%h grant_wait=%0d, required all 0",
                     {nIf.oGNT0, nIf.oGNT1, nIf.oBUSY, nIf.oVALID, nIf.oSRC}, nIf.oBCD, n);
        end
        ptrM = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        nIf.iREQ0 = 1'b1;
        nIf.iBIN0 = 8'($urandom);
        nIf.iREQ1 = 1'b1;
        nIf.iBIN1 = 8'($urandom);
        convert("post_reset", 1);
        convert("post_reset_b", 1);
    endtask

    task automatic test_wide();
        int vals[3];
        vals[0] = 1023;
        vals[1] = int'($urandom_range(0, 1023));
        vals[2] = int'($urandom_range(0, 1023));
        for (int k = 0; k < 3; k++) begin
            int          n = 0;
            int          lat = 0;
            bit          who = (k == 1);
            logic [15:0] expBcd = 16'(toBcd(vals[k], 4));
            if (who) begin
                wIf.iREQ1 = 1'b1;
                wIf.iBIN1 = 10'(vals[k]);
            end else begin
                wIf.iREQ0 = 1'b1;
                wIf.iBIN0 = 10'(vals[k]);
            end
            do begin
                @(negedge clk);
                n++;
            end while (!(wIf.oGNT0 || wIf.oGNT1) && n < 40);
            wIf.iREQ0 = 1'b0;
            wIf.iREQ1 = 1'b0;
            do begin
                @(negedge clk);
                lat++;
            end while (wIf.oVALID !== 1'b1 && lat < 40);
            tests++;
            if (n != 1 || lat != 10 || wIf.oBCD !== expBcd || wIf.oSRC !== who) begin
                fails++;
                $display("FAIL wide_%0d: grant_wait=%0d lat=%0d bcd=%h src=%b, required 1 10 %h %b",
                         vals[k], n, lat, wIf.oBCD, wIf.oSRC, expBcd, who);
            end
            wIf.iREADY = 1'b1;
            @(negedge clk);
            wIf.iREADY = 1'b0;
        end
    endtask

    initial begin
        rstN       = 1'b0;
        ptrM       = 1'b0;
        nIf.iREQ0  = 1'b0;
        nIf.iREQ1  = 1'b0;
        nIf.iBIN0  = '0;
        nIf.iBIN1  = '0;
        nIf.iREADY = 1'b0;
        wIf.iREQ0  = 1'b0;
        wIf.iREQ1  = 1'b0;
        wIf.iBIN0  = '0;
        wIf.iBIN1  = '0;
        wIf.iREADY = 1'b0;
        test_reset();
        test_single();
        test_boundary();
        test_simultaneous();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
